// File: rtl/count_down_timer.sv
// count_down_timer: loadable down-counter with terminal-count tick, pause, abort and auto-reload
module count_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, reload, reload_n;
  logic             tick_n, take, terminal;
  assign load_ready = (state == IDLE || state == DONE) && !abort;
  assign take       = load_valid && load_ready;
  assign terminal   = count == WIDTH'(1);
  assign busy       = state == RUN;
  assign done       = state == DONE;
  // Next-state: abort beats load beats pause beats decrement; a zero load completes at once
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    tick_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
    end else if (take) begin
      count_n  = load_value;
      reload_n = load_value;
      state_n  = load_value == '0 ? DONE : RUN;
      tick_n   = load_value == '0;
    end else if (state == RUN && !pause) begin
      tick_n  = terminal;
      count_n = terminal ? (auto_reload ? reload : '0) : count - WIDTH'(1);
      state_n = terminal && !auto_reload ? DONE : RUN;
    end
  end
  // State, count, reload value and tick pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tick   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      tick   <= tick_n;
    end
  end
endmodule

// File: tb/tb_count_down_timer.sv
// tb_count_down_timer: directed scoreboard bench for the down-counting timer
module tb_count_down_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_value = '0;
  logic       auto_reload = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] count;
  logic       busy, done, tick;
  logic [10:0] q[$];
  int vectors = 0;
  int miscompares = 0;

  count_down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .auto_reload(auto_reload), .pause(pause),
    .abort(abort), .count(count), .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] c, input logic b, input logic d, input logic t);
    q.push_back({c, b, d, t});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    logic [10:0] e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, {count, busy, done, tick});
    end else begin
      e = q.pop_front();
      vectors++;
      assert ({count, busy, done, tick} === e) else begin
        miscompares++;
        $error("FAIL %s: observed cnt=%0d b=%0b d=%0b t=%0b expected cnt=%0d b=%0b d=%0b t=%0b",
               tag, count, busy, done, tick, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    #2;
    chk("reset_outputs", {count, busy, done, tick}, 32'h0);
    chk("reset_ready", load_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    load_valid = 1'b1; load_value = 8'd5; auto_reload = 1'b0;
    push(8'd5, 1, 0, 0); cyc("t1_load");
    load_valid = 1'b0;
    for (int i = 4; i >= 1; i--) begin push(i[7:0], 1, 0, 0); cyc("t1_count"); end
    push(8'd0, 0, 1, 1); cyc("t1_terminal");
    push(8'd0, 0, 1, 0); cyc("t1_done_hold");
    chk("t1_ready_in_done", load_ready, 1);

    load_valid = 1'b1; load_value = 8'd3; auto_reload = 1'b1;
    push(8'd3, 1, 0, 0); cyc("t2_load");
    load_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push(8'd2, 1, 0, 0); cyc("t2_c2");
      push(8'd1, 1, 0, 0); cyc("t2_c1");
      push(8'd3, 1, 0, 1); cyc("t2_reload");
    end
    abort = 1'b1; #1;
    chk("t2_ready_abort", load_ready, 0);
    push(8'd0, 0, 0, 0); cyc("t2_abort");
    abort = 1'b0;

    load_valid = 1'b1; load_value = 8'd1;
    push(8'd1, 1, 0, 0); cyc("tr_load1");
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin push(8'd1, 1, 0, 1); cyc("tr_back_to_back"); end
    abort = 1'b1;
    push(8'd0, 0, 0, 0); cyc("tr_abort");
    abort = 1'b0; auto_reload = 1'b0;

    load_valid = 1'b1; load_value = 8'd10;
    push(8'd10, 1, 0, 0); cyc("t3_load");
    load_valid = 1'b0;
    for (int i = 9; i >= 7; i--) begin push(i[7:0], 1, 0, 0); cyc("t3_count"); end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin push(8'd7, 1, 0, 0); cyc("t3_pause"); end
    pause = 1'b0;
    for (int i = 6; i >= 1; i--) begin push(i[7:0], 1, 0, 0); cyc("t3_resume"); end
    push(8'd0, 0, 1, 1); cyc("t3_tick_at_14");
    pause = 1'b1;
    push(8'd0, 0, 1, 0); cyc("t3_pause_in_done");
    pause = 1'b0;

    load_valid = 1'b1; load_value = 8'd0;
    push(8'd0, 0, 1, 1); cyc("t4_load0");
    load_valid = 1'b0;
    push(8'd0, 0, 1, 0); cyc("t4_after");

    load_valid = 1'b1; load_value = 8'd6;
    push(8'd6, 1, 0, 0); cyc("t5_load");
    load_valid = 1'b0;
    push(8'd5, 1, 0, 0); cyc("t5_c5");
    push(8'd4, 1, 0, 0); cyc("t5_c4");
    abort = 1'b1; load_valid = 1'b1; load_value = 8'd9; #1;
    chk("t5_ready_abort", load_ready, 0);
    push(8'd0, 0, 0, 0); cyc("t5_abort");
    abort = 1'b0; load_valid = 1'b0;
    push(8'd0, 0, 0, 0); cyc("t5_idle");
    chk("t5_ready_idle", load_ready, 1);

    load_valid = 1'b1; load_value = 8'd8;
    push(8'd8, 1, 0, 0); cyc("t6_load");
    load_valid = 1'b0;
    push(8'd7, 1, 0, 0); cyc("t6_c7");
    #2 rst = 1'b0;
    #1;
    chk("t6_async_reset", {count, busy, done, tick}, 32'h0);
    @(posedge clk); #1;
    chk("t6_reset_held", {count, busy, done, tick}, 32'h0);
    rst = 1'b1;

    load_valid = 1'b1; load_value = 8'd255;
    push(8'd255, 1, 0, 0); cyc("t6_load255");
    load_valid = 1'b0;
    for (int i = 254; i >= 1; i--) begin push(i[7:0], 1, 0, 0); cyc("t6_count"); end
    push(8'd0, 0, 1, 1); cyc("t6_tick255");
    push(8'd0, 0, 1, 0); cyc("t6_no_wrap");

    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
